// File: rtl/masked_and_feeder.sv
// rtl/masked_and_feeder.sv - Boolean-share splitter, refresh-randomness source and result recombiner
// in front of a D-share masked AND gadget.
module masked_and_feeder #(
  parameter int          D       = 2,
  parameter logic [31:0] SEED    = 32'hACE1_2025,
  parameter int          TIMEOUT = 16,
  localparam int         RSIZE   = D*(D-1)/2,
  localparam int         RNEED   = 2*(D-1)+RSIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             a,
  input  logic             b,
  output logic             busy,
  output logic [0:D-1]     ina,
  output logic [0:D-1]     inb,
  output logic [0:RSIZE-1] rin,
  output logic             and_enable,
  input  logic             and_done,
  input  logic [0:D-1]     and_out,
  output logic             result,
  output logic             result_valid,
  output logic             err
);

  localparam int            CW       = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] TO_CNT   = CW'(TIMEOUT);
  localparam logic [31:0]   SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0]   POLY     = 32'h8020_0003;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      lfsr_q, lfsr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_q, a_d, b_q, b_d;
  logic [0:D-1]     ina_q, ina_d, inb_q, inb_d;
  logic [0:RSIZE-1] rin_q, rin_d;
  logic             en_q, en_d;
  logic             result_q, result_d;
  logic             rv_q, rv_d;
  logic             err_q, err_d;

  logic [RNEED-1:0] rnd;
  logic [0:D-1]     sh_a, sh_b;
  logic [0:RSIZE-1] sh_r;
  logic             par_a, par_b;

  assign rnd = lfsr_q[RNEED-1:0];

  // The last share absorbs the operand so the XOR of all shares equals the plain bit.
  always_comb begin
    sh_a  = '0;
    sh_b  = '0;
    sh_r  = '0;
    par_a = a_q;
    par_b = b_q;
    for (int i = 0; i < D-1; i++) begin
      sh_a[i] = rnd[i];
      sh_b[i] = rnd[D-1+i];
      par_a   = par_a ^ rnd[i];
      par_b   = par_b ^ rnd[D-1+i];
    end
    sh_a[D-1] = par_a;
    sh_b[D-1] = par_b;
    for (int k = 0; k < RSIZE; k++) begin
      sh_r[k] = rnd[2*(D-1)+k];
    end
  end

  always_comb begin
    state_d  = state_q;
    lfsr_d   = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : 32'h0);
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    ina_d    = ina_q;
    inb_d    = inb_q;
    rin_d    = rin_q;
    en_d     = en_q;
    result_d = result_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ina_d   = sh_a;
        inb_d   = sh_b;
        rin_d   = sh_r;
        en_d    = 1'b1;
        cnt_d   = CW'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        if (and_done) begin
          result_d = ^and_out;
          en_d     = 1'b0;
          rv_d     = 1'b1;
          state_d  = S_OUT;
        end else if (cnt_q == TO_CNT) begin
          en_d    = 1'b0;
          err_d   = 1'b1;
          ina_d   = '0;
          inb_d   = '0;
          rin_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_OUT: begin
        ina_d   = '0;
        inb_d   = '0;
        rin_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED_EFF;
      cnt_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      ina_q    <= '0;
      inb_q    <= '0;
      rin_q    <= '0;
      en_q     <= 1'b0;
      result_q <= 1'b0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ina_q    <= ina_d;
      inb_q    <= inb_d;
      rin_q    <= rin_d;
      en_q     <= en_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign ina          = ina_q;
  assign inb          = inb_q;
  assign rin          = rin_q;
  assign and_enable   = en_q;
  assign result       = result_q;
  assign result_valid = rv_q;
  assign err          = err_q;

endmodule

// File: tb/tb_masked_and_feeder.sv
// tb/tb_masked_and_feeder.sv - self-checking bench for masked_and_feeder (D=2, TIMEOUT=16).
module tb_masked_and_feeder;

  localparam int          D       = 2;
  localparam int          TIMEOUT = 16;
  localparam logic [31:0] SEED    = 32'hACE1_2025;
  localparam int          RSIZE   = D*(D-1)/2;

  logic             clk = 1'b0;
  logic             rst, start, a, b, and_done;
  logic [0:D-1]     and_out;
  logic             busy, and_enable, result, result_valid, err;
  logic [0:D-1]     ina, inb;
  logic [0:RSIZE-1] rin;

  masked_and_feeder #(.D(D), .SEED(SEED), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .busy(busy),
    .ina(ina), .inb(inb), .rin(rin), .and_enable(and_enable),
    .and_done(and_done), .and_out(and_out), .result(result),
    .result_valid(result_valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rv_count = 0;
  int err_count = 0;
  logic [31:0] m_lfsr;
  logic        m_result;

  always @(negedge clk) begin
    if (result_valid === 1'b1) rv_count++;
    if (err === 1'b1) err_count++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) m_lfsr = SEED;
    else     m_lfsr = lfsr_next(m_lfsr);
    #1;
  endtask

  task automatic exp_shares(input logic [31:0] r, input logic ea, input logic eb,
                            output logic [0:D-1] sa, output logic [0:D-1] sb,
                            output logic [0:RSIZE-1] sr);
    logic pa, pb;
    pa = ea;
    pb = eb;
    for (int i = 0; i < D-1; i++) begin
      sa[i] = r[i];
      sb[i] = r[D-1+i];
      pa = pa ^ r[i];
      pb = pb ^ r[D-1+i];
    end
    sa[D-1] = pa;
    sb[D-1] = pb;
    for (int k = 0; k < RSIZE; k++) sr[k] = r[2*(D-1)+k];
  endtask

  // Gadget stand-in: fresh random sharing of the AND of the recombined inputs.
  function automatic logic [0:D-1] gadget_shares(input logic v);
    logic [0:D-1] s;
    logic p;
    s = D'($urandom);
    p = v;
    for (int i = 0; i < D-1; i++) p = p ^ s[i];
    s[D-1] = p;
    return s;
  endfunction

  task automatic run_op(input logic ia, input logic ib, input int lat, input logic exp_res,
                        input bit poke, output logic [0:D-1] got_ina,
                        output logic [0:RSIZE-1] got_rin, output logic [31:0] r_used);
    int rv0;
    logic [0:D-1] ea, eb;
    logic [0:RSIZE-1] er;
    rv0 = rv_count;
    start = 1'b1; a = ia; b = ib;
    tick();
    start = 1'b0; a = 1'($urandom); b = 1'($urandom);
    chk("load_busy", busy, 1);
    chk("load_en", and_enable, 0);
    r_used = m_lfsr;
    exp_shares(r_used, ia, ib, ea, eb, er);
    if (poke) start = 1'b1;
    tick();
    chk("ina", ina, ea);
    chk("inb", inb, eb);
    chk("rin", rin, er);
    chk("xor_ina", ^ina, ia);
    chk("xor_inb", ^inb, ib);
    chk("run_en", and_enable, 1);
    got_ina = ina;
    got_rin = rin;
    for (int k = 1; k <= lat; k++) begin
      if (poke) start = 1'($urandom);
      if (k == lat) begin
        and_done = 1'b1;
        and_out  = gadget_shares((^ina) & (^inb));
      end else begin
        and_out = D'($urandom);
      end
      tick();
      and_done = 1'b0;
      if (k < lat) begin
        chk("hold_ina", ina, ea);
        chk("hold_inb", inb, eb);
        chk("hold_rin", rin, er);
        chk("hold_en", and_enable, 1);
        chk("early_rv", result_valid, 0);
      end else begin
        chk("rv", result_valid, 1);
        chk("result", result, exp_res);
        chk("out_en", and_enable, 0);
        chk("out_err", err, 0);
        chk("out_busy", busy, 1);
      end
    end
    tick();
    start = 1'b0;
    chk("rv_pulse", result_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ina", ina, 0);
    chk("idle_inb", inb, 0);
    chk("idle_rin", rin, 0);
    chk("rv_count", rv_count - rv0, 1);
    m_result = exp_res;
  endtask

  typedef struct {
    logic a;
    logic b;
    int   lat;
    logic exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [0:D-1]     i1, i2;
    logic [0:RSIZE-1] r1, r2;
    logic [31:0]      u1, u2;
    logic [0:D-1]     ea1, eb1, ea2, eb2;
    logic [0:RSIZE-1] er1, er2;
    int e0, rv0;
    logic ra, rb;

    tbl[0] = '{1'b0, 1'b0, 3, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 3, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 3, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 3, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 16, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 16, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 2, 1'b0};

    rst = 1'b1; start = 1'b0; a = 1'b0; b = 1'b0; and_done = 1'b0; and_out = '0;
    m_lfsr = SEED; m_result = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_ina", ina, 0);
    chk("rst_inb", inb, 0);
    chk("rst_rin", rin, 0);
    chk("rst_en", and_enable, 0);
    chk("rst_result", result, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", err, 0);
    rst = 1'b0;
    tick();

    for (int t = 0; t < 8; t++)
      run_op(tbl[t].a, tbl[t].b, tbl[t].lat, tbl[t].exp, 1'b0, i1, r1, u1);

    // and_done outside RUN has no effect
    rv0 = rv_count;
    and_done = 1'b1; and_out = 2'b01;
    repeat (2) tick();
    and_done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_rv", rv_count - rv0, 0);
    chk("idle_done_result", result, m_result);

    // freshness: back-to-back a=b=1
    run_op(1'b1, 1'b1, 3, 1'b1, 1'b0, i1, r1, u1);
    run_op(1'b1, 1'b1, 3, 1'b1, 1'b0, i2, r2, u2);
    exp_shares(u1, 1'b1, 1'b1, ea1, eb1, er1);
    exp_shares(u2, 1'b1, 1'b1, ea2, eb2, er2);
    chk("fresh", ({i1, r1} != {i2, r2}), ({ea1, er1} != {ea2, er2}));

    // start pokes during LOAD/RUN/OUT
    run_op(1'b1, 1'b1, 4, 1'b1, 1'b1, i1, r1, u1);
    run_op(1'b0, 1'b1, 2, 1'b0, 1'b1, i1, r1, u1);

    // timeout
    e0 = err_count;
    start = 1'b1; a = 1'b1; b = 1'b0;
    tick();
    start = 1'b0;
    tick();
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      if (k < TIMEOUT) begin
        if (k == 1 || k == TIMEOUT-1) begin
          chk("to_noerr", err, 0);
          chk("to_en", and_enable, 1);
        end
      end else begin
        chk("to_err", err, 1);
        chk("to_en_off", and_enable, 0);
        chk("to_busy", busy, 0);
        chk("to_ina", ina, 0);
        chk("to_result", result, m_result);
      end
    end
    tick();
    chk("to_err_pulse", err, 0);
    chk("to_err_count", err_count - e0, 1);

    // reset during second RUN cycle
    rv0 = rv_count;
    start = 1'b1; a = 1'b1; b = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_en", and_enable, 0);
    chk("mr_busy", busy, 0);
    chk("mr_ina", ina, 0);
    chk("mr_inb", inb, 0);
    chk("mr_rv", result_valid, 0);
    chk("mr_err", err, 0);
    m_result = 1'b0;
    repeat (4) tick();
    chk("mr_no_rv", rv_count - rv0, 0);
    run_op(1'b1, 1'b1, 3, 1'b1, 1'b0, i1, r1, u1);

    // randomized operations
    for (int n = 0; n < 16; n++) begin
      ra = 1'($urandom);
      rb = 1'($urandom);
      run_op(ra, rb, $urandom_range(1, 6), ra & rb, 1'($urandom), i1, r1, u1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
